dmem_access_controller: RTL and testbench
=========================================

Name: dmem_access_controller

Overview:
- Sequences every data-memory load/store issued by the CPU datapath against a multi-cycle data memory.
- Latches the request, drives the memory strobes and holds BUSYWAIT so the program counter and register-file write stall until the access completes.
- Sits between the CPU's load/store control signals and the data memory.
- A watchdog aborts accesses the memory never finishes and raises a sticky error flag.

Parameters:
DATA_WIDTH, 8, width of CPU and memory data buses
ADDR_WIDTH, 8, width of CPU and memory address buses
TIMEOUT_CYCLES, 255, maximum ACCESS cycles with MEM_BUSYWAIT high before abort (1..255)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
READ  in  1  CPU load request, level, held until BUSYWAIT low
WRITE  in  1  CPU store request, level, held until BUSYWAIT low
ADDRESS  in  ADDR_WIDTH  CPU access address (ALU result)
WRITEDATA  in  DATA_WIDTH  CPU store data (register operand)
READDATA  out  DATA_WIDTH  load result to register file
BUSYWAIT  out  1  stall to PC and register file
MEM_READ  out  1  memory read strobe
MEM_WRITE  out  1  memory write strobe
MEM_ADDRESS  out  ADDR_WIDTH  latched address to memory
MEM_WRITEDATA  out  DATA_WIDTH  latched store data to memory
MEM_READDATA  in  DATA_WIDTH  memory read data, valid when MEM_BUSYWAIT low
MEM_BUSYWAIT  in  1  memory busy, high while access in progress
ERROR  out  1  sticky: timeout or illegal READ&WRITE seen

Behaviour:
- One clock CLK; reset is RESET, asynchronous and active-high.
- Reset, including mid-access:
  - state IDLE, counter 0.
  - All outputs 0 immediately: READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA and ERROR.
  - No completion reported for an aborted access.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - BUSYWAIT = READ|WRITE, combinational, so the PC stalls on the request cycle.
  - On an edge with READ|WRITE: latch ADDRESS->MEM_ADDRESS and WRITEDATA->MEM_WRITEDATA, latch the op, clear counter, go ACCESS.
  - READ&WRITE together: treated as READ; ERROR set.
- ACCESS:
  - MEM_READ or MEM_WRITE (latched op) high; BUSYWAIT high.
  - Edge with MEM_BUSYWAIT low: for reads, MEM_READDATA->READDATA; go DONE.
  - Edge with MEM_BUSYWAIT high: counter+1. When counter reaches TIMEOUT_CYCLES: set ERROR, READDATA=0, go DONE.
  - CPU input changes are ignored during ACCESS.
- DONE:
  - Exactly one cycle. Strobes low, BUSYWAIT low; the PC advances and the register file writes READDATA at this edge.
  - READ/WRITE still asserted by the old instruction are ignored.
  - Next state is IDLE.
- READDATA holds its value until the next completed read. Writes leave READDATA unchanged.
- Latency: with memory busy for L>=0 ACCESS cycles, BUSYWAIT is high for L+2 cycles (1 IDLE + L+1 ACCESS), then DONE.
- Strobes are never high in IDLE or DONE. MEM_READ and MEM_WRITE are never both high.
- ERROR clears only on RESET.
- Counter is 8 bits; no wrap is possible because abort fires at TIMEOUT_CYCLES.
- Back-to-back accesses: a new request is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- Load, L=3: ADDRESS=0x2A, MEM_READDATA=0x5C -> MEM_READ high 4 cycles with MEM_ADDRESS=0x2A; BUSYWAIT high 5 cycles; READDATA=0x5C in DONE; ERROR=0.
- Store, L=0: ADDRESS=0x10, WRITEDATA=0xF3 -> MEM_WRITE high exactly 1 cycle with MEM_WRITEDATA=0xF3; BUSYWAIT high 2 cycles; READDATA unchanged.
- Timeout, TIMEOUT_CYCLES=4, MEM_BUSYWAIT stuck high -> 4 ACCESS cycles, then DONE with READDATA=0x00 and ERROR=1; ERROR stays 1 over a later good load.
- Simultaneous READ=1 and WRITE=1 -> only MEM_READ strobes; ERROR=1; access completes normally.
- RESET pulsed during ACCESS (L=6, cycle 3) -> MEM_READ, BUSYWAIT and READDATA go 0 without waiting for CLK; state IDLE; a fresh load completes normally.
- Back-to-back load 0x01 then store 0x02, L=1 -> second MEM_WRITE starts 2 cycles after the first DONE; no duplicate access of 0x01 during DONE.

Source files
------------

// File: rtl/dmem_access_controller_if.sv
// CPU-side load/store signals and data-memory strobes for the data-memory access controller.
// The controller takes the master modport. The CPU/memory environment takes the slave modport.
interface dmem_access_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [DATA_WIDTH-1:0] WRITEDATA;
  logic [DATA_WIDTH-1:0] READDATA;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
  logic [DATA_WIDTH-1:0] MEM_WRITEDATA;
  logic [DATA_WIDTH-1:0] MEM_READDATA;
  logic                  MEM_BUSYWAIT;
  logic                  ERROR;

  modport master (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ERROR
  );

  modport slave (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ERROR
  );
endinterface

// File: rtl/dmem_access_controller.sv
// Sequences CPU loads/stores against a multi-cycle data memory and stalls the CPU via BUSYWAIT.
// A watchdog aborts accesses the memory never finishes. ERROR is sticky until reset.
module dmem_access_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RESET,
  dmem_access_controller_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  busy_s;
  logic [7:0]            cnt_inc_s;

  // State register and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      op_write_q  <= 1'b0;
      cnt_q       <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Next-state logic, request latching, completion/timeout handling and BUSYWAIT.
  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    busy_s      = 1'b0;
    cnt_inc_s   = cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        // Stall on the request cycle itself. Held low while RESET is asserted.
        busy_s = (bus.READ | bus.WRITE) & ~RESET;
        if (bus.READ | bus.WRITE) begin
          state_d     = ST_ACCESS;
          op_write_d  = bus.WRITE & ~bus.READ;
          mem_addr_d  = bus.ADDRESS;
          mem_wdata_d = bus.WRITEDATA;
          cnt_d       = 8'd0;
          if (bus.READ & bus.WRITE) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        busy_s = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          if (!op_write_q) begin
            rdata_d = bus.MEM_READDATA;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_DONE;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          cnt_d   = cnt_inc_s;
          error_d = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_read_d  = (state_d == ST_ACCESS) & ~op_write_d;
    mem_write_d = (state_d == ST_ACCESS) &  op_write_d;
  end

  assign bus.READDATA      = rdata_q;
  assign bus.BUSYWAIT      = busy_s;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.ERROR         = error_q;

endmodule

// File: tb/tb_dmem_access_controller.sv
// Randomized self-checking bench for dmem_access_controller against a transaction-level model.
module tb_dmem_access_controller;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] exp_rdata;
  logic          exp_error;

  dmem_access_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_access_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, bus.BUSYWAIT}, 32'd0);
    check_eq({tag, "_strobes"}, {30'd0, bus.MEM_READ, bus.MEM_WRITE}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    exp_error = 1'b0;
  endtask

  // One CPU access with memory latency lat, then gap idle cycles.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] mdata,
                           input int lat, input int gap);
    int   busy_n;
    int   stb_n;
    int   bad_n;
    int   j;
    int   exp_busy;
    int   exp_stb;
    logic is_rd;
    logic tmo;
    is_rd    = rd;
    tmo      = (lat >= TMO);
    exp_busy = tmo ? TMO + 1 : lat + 2;
    exp_stb  = tmo ? TMO : lat + 1;
    if (rd && wr) exp_error = 1'b1;
    if (tmo) begin
      exp_error = 1'b1;
      exp_rdata = '0;
    end else if (is_rd) begin
      exp_rdata = mdata;
    end

    @(negedge clk);
    bus.READ = rd;
    bus.WRITE = wr;
    bus.ADDRESS = addr;
    bus.WRITEDATA = wdata;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = DW'($urandom);
    #1;
    check_eq("req_busy", {31'd0, bus.BUSYWAIT}, 32'd1);
    check_eq("req_strobes", {30'd0, bus.MEM_READ, bus.MEM_WRITE}, 32'd0);
    busy_n = 1;
    stb_n = 0;
    bad_n = 0;
    j = 0;
    while (j < 64) begin
      @(negedge clk);
      j++;
      bus.ADDRESS = AW'($urandom);
      bus.WRITEDATA = DW'($urandom);
      bus.MEM_BUSYWAIT = (j <= lat);
      bus.MEM_READDATA = (j <= lat) ? DW'($urandom) : mdata;
      #1;
      if (!bus.BUSYWAIT) break;
      busy_n++;
      if (bus.MEM_READ || bus.MEM_WRITE) stb_n++;
      if (bus.MEM_READ !== is_rd || bus.MEM_WRITE !== !is_rd ||
          bus.MEM_ADDRESS !== addr || (!is_rd && bus.MEM_WRITEDATA !== wdata)) bad_n++;
    end
    check_eq("busy_cycles", busy_n, exp_busy);
    check_eq("strobe_cycles", stb_n, exp_stb);
    check_eq("strobe_content", bad_n, 32'd0);
    check_eq("done_strobes", {30'd0, bus.MEM_READ, bus.MEM_WRITE}, 32'd0);
    check_eq("readdata", {24'd0, bus.READDATA}, {24'd0, exp_rdata});
    check_eq("error", {31'd0, bus.ERROR}, {31'd0, exp_error});
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.READ = 1'b0;
      bus.WRITE = 1'b0;
      #1;
      check_idle_outputs("gap");
    end
  endtask

  // Load with long latency, reset asynchronously in the third ACCESS cycle.
  task automatic reset_mid_access();
    @(negedge clk);
    bus.READ = 1'b1;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h33;
    bus.MEM_BUSYWAIT = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      bus.MEM_BUSYWAIT = 1'b1;
    end
    #1;
    check_eq("pre_rst_read", {31'd0, bus.MEM_READ}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.BUSYWAIT}, 32'd0);
    check_eq("rst_readdata", {24'd0, bus.READDATA}, 32'd0);
    check_eq("rst_error", {31'd0, bus.ERROR}, 32'd0);
    check_eq("rst_mem_addr", {24'd0, bus.MEM_ADDRESS}, 32'd0);
    exp_rdata = '0;
    exp_error = 1'b0;
    @(negedge clk);
    bus.READ = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("post_rst");
  endtask

  initial begin
    int r;
    logic rd;
    logic wr;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = '0;
    bus.WRITEDATA = '0;
    bus.MEM_READDATA = '0;
    bus.MEM_BUSYWAIT = 1'b0;
    exp_rdata = '0;
    exp_error = 1'b0;

    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_readdata", {24'd0, bus.READDATA}, 32'd0);
    check_eq("reset_error", {31'd0, bus.ERROR}, 32'd0);
    check_eq("reset_mem_addr", {24'd0, bus.MEM_ADDRESS}, 32'd0);
    check_eq("reset_mem_wdata", {24'd0, bus.MEM_WRITEDATA}, 32'd0);
    rst = 1'b0;

    do_access(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 3, 1);
    do_access(1'b0, 1'b1, 8'h10, 8'hF3, 8'hAA, 0, 1);
    do_access(1'b1, 1'b0, 8'h01, 8'h00, 8'h77, 1, 0);
    do_access(1'b0, 1'b1, 8'h02, 8'h9E, 8'h55, 1, 1);
    do_access(1'b1, 1'b0, 8'h40, 8'h00, 8'hC3, 10, 1);
    do_access(1'b1, 1'b0, 8'h41, 8'h00, 8'h3C, 2, 1);
    reset_mid_access();
    do_access(1'b1, 1'b0, 8'h50, 8'h00, 8'h99, 2, 1);
    do_access(1'b1, 1'b1, 8'h60, 8'h12, 8'h4B, 1, 1);

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) apply_reset();
      r = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      do_access(rd, wr, AW'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
